// File: rtl/demux_1to8_32b_buf_pkg.sv
// demux_1to8_32b_buf_pkg: shared channel constants and out_data slice helper
package demux_1to8_32b_buf_pkg;
   localparam int NCH  = 8;
   localparam int SELW = 3;
   function automatic int slice_lo(input int ch, input int width);
      return ch * width;
   endfunction
endpackage

// File: rtl/demux_1to8_32b_buf_chan_fifo.sv
// chan_fifo: flop-based per-channel FIFO with asynchronous head read
module chan_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             valid,
   output logic             full
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             do_push, do_pop;
   assign valid   = cnt_q != '0;
   assign full    = cnt_q == (AW+1)'(DEPTH);
   assign head    = mem_q[rd_q];
   assign do_push = push & ~full;
   assign do_pop  = pop & valid;
   // next state: pointers wrap naturally since DEPTH is a power of two
   always_comb begin
      mem_d = mem_q;
      if (do_push) mem_d[wr_q] = push_data;
      wr_d  = do_push ? wr_q + AW'(1) : wr_q;
      rd_d  = do_pop ? rd_q + AW'(1) : rd_q;
      cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
   end
   // state registers; reset discards all buffered words
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/demux_1to8_32b_buf.sv
// demux_1to8_32b_buf: buffered 1-to-8 demux of WIDTH-bit words with per-channel FIFOs
module demux_1to8_32b_buf
   import demux_1to8_32b_buf_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic               clock,
   input  logic               resetn,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [SELW-1:0]    in_sel,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [NCH*WIDTH-1:0] out_data,
   output logic [NCH-1:0]     out_valid,
   input  logic [NCH-1:0]     out_ready,
   output logic [15:0]        acc_count,
   output logic               busy
);
   logic [NCH-1:0] full;
   logic           accept;
   logic [15:0]    acc_count_q, acc_count_d;
   assign in_ready  = ~full[in_sel];
   assign accept    = in_valid & in_ready;
   assign acc_count = acc_count_q;
   assign busy      = |out_valid;
   for (genvar c = 0; c < NCH; c++) begin : g_ch
      chan_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
         .clock     (clock),
         .resetn    (resetn),
         .push      (accept & (in_sel == SELW'(c))),
         .push_data (in_data),
         .pop       (out_ready[c]),
         .head      (out_data[slice_lo(c, WIDTH) +: WIDTH]),
         .valid     (out_valid[c]),
         .full      (full[c])
      );
   end
   // accepted-word counter, wraps modulo 2^16
   always_comb begin
      acc_count_d = accept ? acc_count_q + 16'd1 : acc_count_q;
   end
   // counter register
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) acc_count_q <= '0;
      else         acc_count_q <= acc_count_d;
   end
endmodule

// File: tb/tb_demux_1to8_32b_buf.sv
// tb_demux_1to8_32b_buf: directed self-checking bench for demux_1to8_32b_buf
module tb_demux_1to8_32b_buf;
   logic          clock = 1'b0;
   logic          resetn = 1'b0;
   logic [31:0]   in_data = '0;
   logic [2:0]    in_sel = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [255:0]  out_data;
   logic [7:0]    out_valid;
   logic [7:0]    out_ready = '0;
   logic [15:0]   acc_count;
   logic          busy;
   int checks = 0;
   int failures = 0;

   demux_1to8_32b_buf dut (
      .clock     (clock),
      .resetn    (resetn),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .acc_count (acc_count),
      .busy      (busy)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      out_ready = '0;
      resetn    = 1'b0;
      step();
      resetn    = 1'b1;
      #1;
   endtask

   task automatic push(input logic [2:0] s, input logic [31:0] d);
      in_sel   = s;
      in_data  = d;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      #2;
      checks++;
      if (out_valid !== 8'h00) begin failures++; $display("FAIL reset_out_valid got=%h exp=00", out_valid); end
      checks++;
      if (out_data !== 256'd0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
      checks++;
      if (acc_count !== 16'd0) begin failures++; $display("FAIL reset_acc got=%h exp=0000", acc_count); end
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      step();
      resetn = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_single_push();
      do_reset();
      push(3'd5, 32'hDEADBEEF);
      checks++;
      if (out_valid !== 8'h20) begin failures++; $display("FAIL single_valid got=%h exp=20", out_valid); end
      checks++;
      if (out_data[5*32 +: 32] !== 32'hDEADBEEF) begin failures++; $display("FAIL single_data got=%h exp=deadbeef", out_data[5*32 +: 32]); end
      checks++;
      if (acc_count !== 16'd1) begin failures++; $display("FAIL single_acc got=%h exp=0001", acc_count); end
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", busy); end
   endtask

   task automatic test_full_and_drain();
      do_reset();
      push(3'd2, 32'h11);
      push(3'd2, 32'h22);
      in_sel = 3'd2;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL full_ready_sel2 got=%b exp=0", in_ready); end
      in_sel = 3'd3;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL full_ready_sel3 got=%b exp=1", in_ready); end
      push(3'd2, 32'h33);
      checks++;
      if (acc_count !== 16'd2) begin failures++; $display("FAIL stall_acc got=%h exp=0002", acc_count); end
      checks++;
      if (out_data[2*32 +: 32] !== 32'h11) begin failures++; $display("FAIL stall_head got=%h exp=00000011", out_data[2*32 +: 32]); end
      in_sel    = 3'd2;
      in_data   = 32'h33;
      in_valid  = 1'b1;
      out_ready = 8'h04;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL drain_ready_same_cycle got=%b exp=0", in_ready); end
      step();
      out_ready = 8'h00;
      #1;
      checks++;
      if (out_data[2*32 +: 32] !== 32'h22) begin failures++; $display("FAIL drain_head got=%h exp=00000022", out_data[2*32 +: 32]); end
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL drain_ready_next got=%b exp=1", in_ready); end
      checks++;
      if (acc_count !== 16'd2) begin failures++; $display("FAIL drain_acc got=%h exp=0002", acc_count); end
      in_valid = 1'b0;
   endtask

   task automatic test_push_pop_same();
      do_reset();
      push(3'd0, 32'hA);
      in_sel    = 3'd0;
      in_data   = 32'hB;
      in_valid  = 1'b1;
      out_ready = 8'h01;
      step();
      in_valid  = 1'b0;
      out_ready = 8'h00;
      #1;
      checks++;
      if (out_data[31:0] !== 32'hB) begin failures++; $display("FAIL pushpop_head got=%h exp=0000000b", out_data[31:0]); end
      checks++;
      if (out_valid !== 8'h01) begin failures++; $display("FAIL pushpop_valid got=%h exp=01", out_valid); end
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL pushpop_count1_ready got=%b exp=1", in_ready); end
      push(3'd0, 32'hC);
      checks++;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL pushpop_count2_ready got=%b exp=0", in_ready); end
      checks++;
      if (acc_count !== 16'd3) begin failures++; $display("FAIL pushpop_acc got=%h exp=0003", acc_count); end
   endtask

   task automatic test_all_channels();
      do_reset();
      for (int i = 0; i < 8; i++) push(3'(i), 32'(i));
      checks++;
      if (out_valid !== 8'hFF) begin failures++; $display("FAIL allch_valid got=%h exp=ff", out_valid); end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (out_data[i*32 +: 32] !== 32'(i)) begin failures++; $display("FAIL allch_data ch=%0d got=%h exp=%h", i, out_data[i*32 +: 32], 32'(i)); end
      end
      out_ready = 8'hFF;
      step();
      out_ready = 8'h00;
      checks++;
      if (out_valid !== 8'h00) begin failures++; $display("FAIL allch_drain_valid got=%h exp=00", out_valid); end
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL allch_busy got=%b exp=0", busy); end
      checks++;
      if (acc_count !== 16'd8) begin failures++; $display("FAIL allch_acc got=%h exp=0008", acc_count); end
   endtask

   task automatic test_async_reset();
      do_reset();
      push(3'd1, 32'h100);
      push(3'd3, 32'h300);
      push(3'd1, 32'h101);
      checks++;
      if (out_valid !== 8'h0A) begin failures++; $display("FAIL areset_pre_valid got=%h exp=0a", out_valid); end
      #2;
      resetn = 1'b0;
      #1;
      checks++;
      if (out_valid !== 8'h00) begin failures++; $display("FAIL areset_valid got=%h exp=00", out_valid); end
      checks++;
      if (acc_count !== 16'd0) begin failures++; $display("FAIL areset_acc got=%h exp=0000", acc_count); end
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL areset_busy got=%b exp=0", busy); end
      step();
      resetn = 1'b1;
      in_sel = 3'd1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL areset_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_acc_wrap();
      do_reset();
      out_ready = 8'hFF;
      in_sel    = 3'd0;
      in_valid  = 1'b1;
      for (int i = 0; i < 65535; i++) begin
         in_data = 32'(i);
         step();
      end
      in_valid = 1'b0;
      checks++;
      if (acc_count !== 16'hFFFF) begin failures++; $display("FAIL wrap_pre got=%h exp=ffff", acc_count); end
      checks++;
      if (out_data[31:0] !== 32'd65534) begin failures++; $display("FAIL wrap_head got=%h exp=0000fffe", out_data[31:0]); end
      push(3'd4, 32'h44);
      checks++;
      if (acc_count !== 16'h0000) begin failures++; $display("FAIL wrap_post got=%h exp=0000", acc_count); end
      checks++;
      if (out_valid !== 8'h10) begin failures++; $display("FAIL wrap_valid got=%h exp=10", out_valid); end
      out_ready = 8'h00;
   endtask

   initial begin
      test_reset();
      test_single_push();
      test_full_and_drain();
      test_push_pop_same();
      test_all_channels();
      test_async_reset();
      test_acc_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
